// File: rtl/u_xmit_fifo.sv
// Transmit byte queue feeding the UART transmitter handshake (xmitH / xmit_doneH).
// Optional queue flush input enabled by defining TXQ_FLUSH_EN.
module u_xmit_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_l,
  input  logic [7:0]        wr_dataH,
  input  logic              wr_enH,
  output logic              fullH,
  output logic              emptyH,
  output logic [ADDR_W:0]   countH,
  output logic              xmitH,
  output logic [7:0]        xmit_dataH,
  input  logic              xmit_doneH,
  output logic              ovfH,
  output logic              toutH,
`ifdef TXQ_FLUSH_EN
  input  logic              flushH,
`endif
  input  logic              err_clrH
);

  localparam int unsigned TmoW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

  state_e              state;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     count;
  logic [TmoW-1:0]     tmo_cnt;

  logic flush;
  logic pop;
  logic wr_acc;
  logic ovf_set;
  logic tout_set;

`ifdef TXQ_FLUSH_EN
  assign flush = flushH;
`else
  assign flush = 1'b0;
`endif

  assign fullH  = (count == (ADDR_W+1)'(DEPTH));
  assign emptyH = (count == '0);
  assign countH = count;
  assign xmitH  = (state == StLaunch);

  assign pop      = (state == StIdle) && !emptyH && xmit_doneH && !flush;
  // A same-cycle pop frees the slot, so a write to a full queue still lands.
  assign wr_acc   = wr_enH && !flush && (!fullH || pop);
  assign ovf_set  = wr_enH && !flush && fullH && !pop;
  assign tout_set = (state == StWaitBusy) && xmit_doneH && (tmo_cnt == TmoLast);

  always_ff @(posedge sys_clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_dataH;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= StIdle;
      xmit_dataH <= 8'h00;
      tmo_cnt    <= '0;
      ovfH       <= 1'b0;
      toutH      <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (pop)    rd_ptr <= rd_ptr + 1'b1;
        unique case ({wr_acc, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      unique case (state)
        StIdle: begin
          if (pop) begin
            xmit_dataH <= mem[rd_ptr];
            state      <= StLaunch;
          end
        end
        StLaunch: begin
          tmo_cnt <= '0;
          state   <= StWaitBusy;
        end
        StWaitBusy: begin
          if (!xmit_doneH) begin
            state <= StWaitDone;
          end else if (tmo_cnt == TmoLast) begin
            state <= StIdle;  // launch lost; byte is dropped, not retried
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        StWaitDone: begin
          if (xmit_doneH) state <= StIdle;
        end
        default: state <= StIdle;
      endcase

      if (ovf_set)       ovfH <= 1'b1;
      else if (err_clrH) ovfH <= 1'b0;

      if (tout_set)      toutH <= 1'b1;
      else if (err_clrH) toutH <= 1'b0;
    end
  end

endmodule
